// File: rtl/if_fetch_queue.sv
// Pipelined instruction-fetch stage: issues in-order memory requests, buffers
// returned instructions with their PCs, and hands them to decode via valid/ready.
module if_fetch_queue #(
  parameter int unsigned        ADDR_W          = 32,
  parameter int unsigned        INST_W          = 32,
  parameter int unsigned        DEPTH           = 4,
  parameter int unsigned        MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC        = {ADDR_W{1'b0}},
  parameter int unsigned        PC_STEP         = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect_i,
  input  logic [ADDR_W-1:0]         redirect_pc_i,
  output logic                      mem_req_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [INST_W-1:0]         mem_rdata_i,
  output logic                      inst_valid_o,
  output logic [INST_W-1:0]         inst_o,
  output logic [ADDR_W-1:0]         pc_o,
  input  logic                      inst_ready_i,
  output logic [$clog2(DEPTH):0]    fifo_count_o
);

  localparam int unsigned        PTR_W   = $clog2(DEPTH);
  localparam int unsigned        CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   MAXO_C  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0]  STEP_C  = ADDR_W'(PC_STEP);
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0]   PTR_ZERO = {PTR_W{1'b0}};

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic [CNT_W:0]    credit_sum_s;
  logic              req_s, grant_s, rsp_s, push_s, drop_s, pop_s, valid_s;

  // A request is only issued when a FIFO slot is already reserved for its response.
  assign credit_sum_s = {1'b0, count_q} + {1'b0, outst_q};
  assign req_s   = rst && !redirect_i && (outst_q < MAXO_C) && (credit_sum_s < {1'b0, DEPTH_C});
  assign grant_s = req_s && mem_gnt_i;
  // Responses with nothing outstanding are protocol violations and are ignored.
  assign rsp_s   = mem_rvalid_i && (outst_q != CNT_ZERO);
  assign push_s  = rsp_s && !redirect_i && (discard_q == CNT_ZERO);
  assign drop_s  = rsp_s && !redirect_i && (discard_q != CNT_ZERO);
  assign valid_s = (count_q != CNT_ZERO);
  assign pop_s   = valid_s && inst_ready_i && !redirect_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (redirect_i) begin
      // Everything still in flight becomes stale, including nothing granted this cycle.
      fetch_pc_d = redirect_pc_i;
      resp_pc_d  = redirect_pc_i;
      rd_ptr_d   = PTR_ZERO;
      wr_ptr_d   = PTR_ZERO;
      count_d    = CNT_ZERO;
      outst_d    = outst_q - CNT_W'(rsp_s);
      discard_d  = outst_q - CNT_W'(rsp_s);
    end else begin
      fetch_pc_d = grant_s ? (fetch_pc_q + STEP_C) : fetch_pc_q;
      resp_pc_d  = push_s  ? (resp_pc_q + STEP_C)  : resp_pc_q;
      wr_ptr_d   = wr_ptr_q + PTR_W'(push_s);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop_s);
      count_d    = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      outst_d    = outst_q + CNT_W'(grant_s) - CNT_W'(rsp_s);
      discard_d  = discard_q - CNT_W'(drop_s);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= PTR_ZERO;
      wr_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      outst_q    <= CNT_ZERO;
      discard_q  <= CNT_ZERO;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= {ADDR_W{1'b0}};
        inst_mem_q[i] <= {INST_W{1'b0}};
      end
    end else if (push_s) begin
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      inst_mem_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

  assign mem_req_o    = req_s;
  assign mem_addr_o   = fetch_pc_q;
  assign inst_valid_o = valid_s;
  assign inst_o       = valid_s ? inst_mem_q[rd_ptr_q] : {INST_W{1'b0}};
  assign pc_o         = valid_s ? pc_mem_q[rd_ptr_q]   : {ADDR_W{1'b0}};
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a latency-configurable in-order memory responder.
module tb_if_fetch_queue;

  localparam logic [31:0] XK = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_ready_i;
  logic [2:0]  fifo_count_o;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          auto_rsp = 1'b1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  if_fetch_queue dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o),
    .inst_ready_i(inst_ready_i), .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: log grants for the responder, then present any due response.
  task automatic tick();
    if (mem_req_o && mem_gnt_i) begin
      pend_addr.push_back(mem_addr_o);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("credit_bound", 64'((32'(fifo_count_o) + 32'(pend_addr.size())) <= 32'd4), 64'd1);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    if (auto_rsp && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = pend_addr[0] ^ XK;
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; inst_ready_i = 1'b0;
    auto_rsp = 1'b1;
    pend_addr.delete();
    pend_due.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst(input logic gnt, input logic rdy, input int l);
    mem_gnt_i = gnt; inst_ready_i = rdy; lat = l;
    rst = 1'b1;
    cyc = 0;
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_req",   64'(mem_req_o),    64'd0);
    chk("rst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst",  64'(inst_o),       64'd0);
    chk("rst_pc",    64'(pc_o),         64'd0);
    chk("rst_count", 64'(fifo_count_o), 64'd0);
    chk("rst_addr",  64'(mem_addr_o),   64'd0);

    // Single-cycle memory, ID always ready: one instruction per cycle from cycle 2.
    release_rst(1'b1, 1'b1, 1);
    chk("t1_req0",  64'(mem_req_o),  64'd1);
    chk("t1_addr0", 64'(mem_addr_o), 64'd0);
    tick();
    chk("t1_c1_valid", 64'(inst_valid_o), 64'd0);
    chk("t1_c1_addr",  64'(mem_addr_o),   64'h4);
    tick();
    for (int k = 0; k < 6; k++) begin
      logic [31:0] epc;
      epc = 32'(k * 4);
      chk("t1_valid", 64'(inst_valid_o), 64'd1);
      chk("t1_pc",    64'(pc_o),         64'(epc));
      chk("t1_inst",  64'(inst_o),       64'(epc ^ XK));
      chk("t1_count", 64'(fifo_count_o), 64'd1);
      tick();
    end

    // ID stalled for 10 cycles: FIFO fills to 4, requests stop, nothing lost.
    do_reset();
    release_rst(1'b1, 1'b0, 1);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        chk("t2_c4_req",   64'(mem_req_o),    64'd0);
        chk("t2_c4_count", 64'(fifo_count_o), 64'd3);
      end
      if (c == 9) begin
        chk("t2_full_count", 64'(fifo_count_o), 64'd4);
        chk("t2_full_req",   64'(mem_req_o),    64'd0);
        chk("t2_full_addr",  64'(mem_addr_o),   64'h10);
      end
      tick();
    end
    inst_ready_i = 1'b1;
    #1;
    chk("t2_c10_count", 64'(fifo_count_o), 64'd4);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] epc;
      epc = 32'(k * 4);
      chk("t2_drain_valid", 64'(inst_valid_o), 64'd1);
      chk("t2_drain_pc",    64'(pc_o),         64'(epc));
      chk("t2_drain_inst",  64'(inst_o),       64'(epc ^ XK));
      tick();
    end

    // 3-cycle latency, redirect with two requests in flight.
    do_reset();
    release_rst(1'b1, 1'b1, 3);
    tick();
    tick();
    chk("t3_c2_req", 64'(mem_req_o), 64'd0);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    #1;
    chk("t3_redir_req", 64'(mem_req_o), 64'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("t3_c3_count", 64'(fifo_count_o), 64'd0);
    chk("t3_c3_valid", 64'(inst_valid_o), 64'd0);
    chk("t3_c3_addr",  64'(mem_addr_o),   64'h100);
    tick();
    chk("t3_c4_req",  64'(mem_req_o),  64'd1);
    chk("t3_c4_addr", 64'(mem_addr_o), 64'h100);
    tick();
    chk("t3_c5_count", 64'(fifo_count_o), 64'd0);
    tick();
    tick();
    chk("t3_c7_valid", 64'(inst_valid_o), 64'd0);
    tick();
    chk("t3_c8_valid", 64'(inst_valid_o), 64'd1);
    chk("t3_c8_pc",    64'(pc_o),         64'h100);
    chk("t3_c8_inst",  64'(inst_o),       64'hA5A5A4A5);

    // Redirect together with a response and a pop while 3 entries are held.
    do_reset();
    release_rst(1'b1, 1'b0, 1);
    for (int c = 0; c < 4; c++) tick();
    chk("t4_c4_count", 64'(fifo_count_o), 64'd3);
    inst_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    #1;
    chk("t4_redir_req", 64'(mem_req_o), 64'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("t4_c5_count", 64'(fifo_count_o), 64'd0);
    chk("t4_c5_valid", 64'(inst_valid_o), 64'd0);
    chk("t4_c5_req",   64'(mem_req_o),    64'd1);
    chk("t4_c5_addr",  64'(mem_addr_o),   64'h200);
    tick();
    tick();
    chk("t4_c7_valid", 64'(inst_valid_o), 64'd1);
    chk("t4_c7_pc",    64'(pc_o),         64'h200);
    chk("t4_c7_inst",  64'(inst_o),       64'hA5A5A7A5);

    // Grant withheld for 5 cycles, then fetch wraps past the top of memory.
    do_reset();
    release_rst(1'b0, 1'b1, 1);
    for (int c = 0; c < 5; c++) begin
      chk("t5_hold_req",  64'(mem_req_o),  64'd1);
      chk("t5_hold_addr", 64'(mem_addr_o), 64'd0);
      tick();
    end
    mem_gnt_i = 1'b1;
    #1;
    tick();
    chk("t5_c6_addr", 64'(mem_addr_o), 64'h4);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFFFFFC;
    #1;
    tick();
    redirect_i = 1'b0;
    #1;
    chk("t5_c7_req",  64'(mem_req_o),  64'd1);
    chk("t5_c7_addr", 64'(mem_addr_o), 64'hFFFFFFFC);
    tick();
    chk("t5_wrap_addr", 64'(mem_addr_o), 64'h0);
    tick();
    chk("t5_c9_pc",   64'(pc_o),   64'hFFFFFFFC);
    chk("t5_c9_inst", 64'(inst_o), 64'h5A5A5A59);
    tick();
    chk("t5_c10_pc",   64'(pc_o),   64'h0);
    chk("t5_c10_inst", 64'(inst_o), 64'hA5A5A5A5);

    // Asynchronous reset mid-burst, then a stray response after release.
    do_reset();
    release_rst(1'b1, 1'b0, 1);
    for (int c = 0; c < 3; c++) tick();
    chk("t6_pre_count", 64'(fifo_count_o), 64'd2);
    rst = 1'b0;
    mem_rvalid_i = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    #1;
    chk("t6_async_req",   64'(mem_req_o),    64'd0);
    chk("t6_async_valid", 64'(inst_valid_o), 64'd0);
    chk("t6_async_inst",  64'(inst_o),       64'd0);
    chk("t6_async_pc",    64'(pc_o),         64'd0);
    chk("t6_async_count", 64'(fifo_count_o), 64'd0);
    chk("t6_async_addr",  64'(mem_addr_o),   64'd0);
    @(posedge clk);
    #1;
    auto_rsp = 1'b0;
    release_rst(1'b0, 1'b0, 1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("t6_rel_req",  64'(mem_req_o),  64'd1);
    chk("t6_rel_addr", 64'(mem_addr_o), 64'd0);
    tick();
    chk("t6_stray_count", 64'(fifo_count_o), 64'd0);
    chk("t6_stray_valid", 64'(inst_valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
